// File: rtl/demux_1x4_tdm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : demux_1x4_tdm                                          |
// | Description : 1-to-4 time-division demultiplexer with ready/valid    |
// |               input, per-channel registered outputs held until       |
// |               acknowledged, round-robin or explicit channel select   |
// |               and frame sync that rewinds the round-robin pointer.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module demux_1x4_tdm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             auto,
  input  logic [1:0]       sel,
  input  logic             sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ack,
  output logic [1:0]       ptr
);

  localparam int N_CH = 4;

  logic [WIDTH-1:0] data_q [N_CH];
  logic [WIDTH-1:0] data_d [N_CH];
  logic [3:0]       out_valid_q;
  logic [3:0]       out_valid_d;
  logic [1:0]       ptr_q;
  logic [1:0]       ptr_d;
  logic [1:0]       tgt;
  logic             xfer;

  // Target selection and handshake: a channel can take a word when it is
  // empty or its current word is being acknowledged in the same cycle.
  always_comb begin
    tgt      = auto ? ptr_q : sel;
    in_ready = rst_n & (~out_valid_q[tgt] | out_ack[tgt]);
    xfer     = in_valid & in_ready;
  end

  // Next-state: acks drop valid bits, a transfer loads the target channel
  // (overriding its ack), sync rewinds the pointer after any increment.
  always_comb begin
    data_d      = data_q;
    out_valid_d = out_valid_q & ~out_ack;
    ptr_d       = ptr_q;
    if (xfer) begin
      data_d[tgt]      = in;
      out_valid_d[tgt] = 1'b1;
      if (auto) begin
        ptr_d = ptr_q + 2'd1;
      end
    end
    if (sync) begin
      ptr_d = 2'd0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        data_q[i] <= '0;
      end
      out_valid_q <= 4'b0000;
      ptr_q       <= 2'd0;
    end else begin
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out0      = data_q[0];
  assign out1      = data_q[1];
  assign out2      = data_q[2];
  assign out3      = data_q[3];
  assign out_valid = out_valid_q;
  assign ptr       = ptr_q;

endmodule
`default_nettype wire
